// File: rtl/rt_mem_preloader.sv
// rt_mem_preloader
//   Loads a boot image into port B of the racetrack/LiM dual-port RAM.
//   Words arrive on a valid/ready source. Each word is written to the next
//   word-aligned address. When verify is enabled, each word is then read back
//   and compared. A clean load raises fetch_enable_o so the core can start.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          start pulse, accepted only in IDLE, DONE or ERROR
//   base_addr_i      first byte address (sampled on start, word-aligned)
//   num_words_i      number of words to load (sampled on start)
//   verify_en_i      enable read-back compare (sampled on start)
//   src_valid_i      source handshake: valid
//   src_data_i       source handshake: data
//   src_ready_o      source handshake: ready
//   mem_en_o         port-B request
//   mem_we_o         port-B write enable
//   mem_be_o         port-B byte enables
//   mem_addr_o       port-B byte address
//   mem_wdata_o      port-B write data
//   mem_rdata_i      port-B read data
//   lim_block_o      forces the LiM function/range inputs to zero while busy
//   busy_o           a load is in progress
//   done_o           sticky: the last load completed
//   error_o          sticky: the last load stopped on a verify mismatch
//   err_addr_o       address of the failing word
//   fetch_enable_o   core fetch enable; sticky until reset
//   Every output is a flop.
module rt_mem_preloader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22,
  parameter int CNT_WIDTH  = 16,
  parameter int WR_LAT     = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    num_words_i,
  input  logic                    verify_en_i,
  input  logic                    src_valid_i,
  input  logic [DATA_WIDTH-1:0]   src_data_i,
  output logic                    src_ready_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    lim_block_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic                    fetch_enable_o
);

  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1) + 1;

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(BE_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_W - 1);
  localparam logic [LAT_W-1:0]      LAT_ONE    = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]      WR_LAST    = LAT_W'(WR_LAT - 1);
  localparam logic [LAT_W-1:0]      RD_LAST    = LAT_W'(RD_LAT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // VERIFY is split into a one-cycle request and an RD_LAT-cycle wait.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic                    start_ok_s;
  logic                    accept_s;
  logic                    mismatch_s;
  logic [LAT_W-1:0]        lat_cnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [CNT_WIDTH-1:0]    remaining_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    verify_r;
  logic [ADDR_WIDTH-1:0]   err_addr_r;
  logic                    src_ready_r;
  logic                    mem_en_r;
  logic                    mem_we_r;
  logic [BE_W-1:0]         mem_be_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    fetch_en_r;

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = 1'b0;
    accept_s    = 1'b0;
    mismatch_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          start_ok_s  = 1'b1;
          state_nxt_s = (num_words_i == '0) ? ST_DONE : ST_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        // src_ready_o is high for exactly the cycles spent in LOAD.
        if (src_valid_i) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (lat_cnt_r == WR_LAST) begin
          state_nxt_s = verify_r ? ST_RD_REQ : ST_NEXT;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_RD_REQ: begin
        state_nxt_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // The last wait cycle is the RD_LAT-th cycle after the request.
        if (lat_cnt_r == RD_LAST) begin
          if (mem_rdata_i != data_r) begin
            mismatch_s  = 1'b1;
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_NEXT;
          end
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_NEXT: begin
        state_nxt_s = (remaining_r == CNT_ONE) ? ST_DONE : ST_LOAD;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latency counter. It restarts on every state change and counts only in the timed states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_r <= '0;
    end else if (state_nxt_s != state_r) begin
      lat_cnt_r <= '0;
    end else if ((state_r == ST_WRITE) || (state_r == ST_RD_WAIT)) begin
      lat_cnt_r <= lat_cnt_r + LAT_ONE;
    end else begin
      lat_cnt_r <= lat_cnt_r;
    end
  end

  // Load context: address, word count, latched data, verify mode and error address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= '0;
      remaining_r <= '0;
      data_r      <= '0;
      verify_r    <= 1'b0;
      err_addr_r  <= '0;
    end else begin
      if (start_ok_s) begin
        addr_r      <= base_addr_i & ALIGN_MASK;
        remaining_r <= num_words_i;
        verify_r    <= verify_en_i;
        err_addr_r  <= '0;
      end else if (state_r == ST_NEXT) begin
        // The address wraps naturally at 2**ADDR_WIDTH.
        addr_r      <= addr_r + WORD_BYTES;
        remaining_r <= remaining_r - CNT_ONE;
      end else if (mismatch_s) begin
        err_addr_r  <= addr_r;
      end
      if (accept_s) begin
        data_r <= src_data_i;
      end
    end
  end

  // Output flops are loaded from the next state, so every output tracks the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ready_r <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      fetch_en_r  <= 1'b0;
    end else begin
      src_ready_r <= (state_nxt_s == ST_LOAD);
      mem_en_r    <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_RD_REQ);
      mem_we_r    <= (state_nxt_s == ST_WRITE);
      mem_be_r    <= (state_nxt_s == ST_WRITE) ? '1 : '0;
      busy_r      <= (state_nxt_s == ST_LOAD)   || (state_nxt_s == ST_WRITE) ||
                     (state_nxt_s == ST_RD_REQ) || (state_nxt_s == ST_RD_WAIT) ||
                     (state_nxt_s == ST_NEXT);
      done_r      <= (state_nxt_s == ST_DONE);
      error_r     <= (state_nxt_s == ST_ERROR);
      // Only reset clears fetch enable. A later start does not.
      fetch_en_r  <= fetch_en_r | (state_nxt_s == ST_DONE);
    end
  end

  assign src_ready_o    = src_ready_r;
  assign mem_en_o       = mem_en_r;
  assign mem_we_o       = mem_we_r;
  assign mem_be_o       = mem_be_r;
  assign mem_addr_o     = addr_r;
  assign mem_wdata_o    = data_r;
  assign lim_block_o    = busy_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign error_o        = error_r;
  assign err_addr_o     = err_addr_r;
  assign fetch_enable_o = fetch_en_r;

endmodule

// File: tb/tb_rt_mem_preloader.sv
// Testbench for rt_mem_preloader.
// A memory model on port B logs every write burst and answers reads RD_LAT
// cycles after the request. It can corrupt the read-back of one chosen address.
// Expected images come from plain address arithmetic over the list of words.
module tb_rt_mem_preloader;

  localparam int DW = 32;
  localparam int AW = 22;
  localparam int CW = 16;
  localparam int WR = 4;
  localparam int RD = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [AW-1:0]   base_addr_i;
  logic [CW-1:0]   num_words_i;
  logic            verify_en_i;
  logic            src_valid_i;
  logic [DW-1:0]   src_data_i;
  logic            src_ready_o;
  logic            mem_en_o;
  logic            mem_we_o;
  logic [DW/8-1:0] mem_be_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW-1:0]   mem_rdata_i;
  logic            lim_block_o;
  logic            busy_o;
  logic            done_o;
  logic            error_o;
  logic [AW-1:0]   err_addr_o;
  logic            fetch_enable_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rt_mem_preloader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .WR_LAT(WR), .RD_LAT(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .verify_en_i(verify_en_i), .src_valid_i(src_valid_i),
    .src_data_i(src_data_i), .src_ready_o(src_ready_o), .mem_en_o(mem_en_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .lim_block_o(lim_block_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_addr_o(err_addr_o),
    .fetch_enable_o(fetch_enable_o)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic [DW-1:0] mem [logic [AW-1:0]];
  wr_t           wr_log[$];
  logic [DW-1:0] rd_pipe [0:RD];
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  int            wr_run = 0;
  int            busy_cnt = 0;
  logic          prev_en = 1'b0;
  logic [DW-1:0] run_data = '0;
  bit            run_end = 1'b0;
  bit            fe_exp = 1'b0;

  assign mem_rdata_i = rd_pipe[RD];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Memory model and bus monitor. It samples at the falling edge, midway between active edges.
  always @(negedge clk) begin
    for (int k = RD; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
    if (rst_n && mem_en_o && !mem_we_o)
      rd_pipe[0] = (mem.exists(mem_addr_o) ? mem[mem_addr_o] : DW'($urandom)) ^
                   ((corrupt_en && mem_addr_o == corrupt_addr) ? 32'h1 : 32'h0);
    else
      rd_pipe[0] = DW'($urandom);
    if (!rst_n) begin
      wr_run  = 0;
      prev_en = 1'b0;
    end else begin
      if (mem_en_o && mem_we_o) begin
        if (wr_run == 0) begin
          check("en_low_before_write", 64'(prev_en), 64'(0));
          check("be_all_ones", 64'(mem_be_o), 64'({(DW/8){1'b1}}));
          wr_log.push_back('{mem_addr_o, mem_wdata_o});
          mem[mem_addr_o] = mem_wdata_o;
          run_data = mem_wdata_o;
        end else begin
          check("wdata_stable", 64'(mem_wdata_o), 64'(run_data));
        end
        wr_run++;
      end else if (wr_run != 0) begin
        check("write_len", 64'(wr_run), 64'(WR));
        wr_run = 0;
      end
      prev_en = mem_en_o;
      if (busy_o) busy_cnt++;
      check("lim_eq_busy", 64'(lim_block_o), 64'(busy_o));
    end
  end

  // Reference: the word list and the address arithmetic give the write sequence and the final status.
  task automatic model(input logic [AW-1:0] base, input int n, input bit verify, input bit cen,
                       input logic [AW-1:0] caddr, input logic [DW-1:0] words[$],
                       output wr_t exp_q[$], output bit exp_done, output bit exp_err,
                       output logic [AW-1:0] exp_eaddr);
    longint a;
    exp_q = {};
    exp_done = 1'b1; exp_err = 1'b0; exp_eaddr = '0;
    for (int i = 0; i < n; i++) begin
      a = ((longint'(base) / 4) * 4 + 4 * i) % (longint'(1) << AW);
      exp_q.push_back('{a[AW-1:0], words[i]});
      if (verify && cen && a[AW-1:0] == caddr) begin
        exp_done = 1'b0; exp_err = 1'b1; exp_eaddr = a[AW-1:0];
        break;
      end
    end
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int n, input bit verify, input bit cen,
                          input logic [AW-1:0] caddr, input logic [DW-1:0] words[$],
                          input int max_gap, input bit spam, input string tag,
                          output int busy_cycles);
    wr_t exp_q[$];
    bit exp_done, exp_err;
    logic [AW-1:0] exp_eaddr;
    int cmp_n;
    model(base, n, verify, cen, caddr, words, exp_q, exp_done, exp_err, exp_eaddr);
    corrupt_en = cen; corrupt_addr = caddr;
    @(posedge clk); #1;
    wr_log = {}; busy_cnt = 0; run_end = 1'b0;
    start_i = 1'b1; base_addr_i = base; num_words_i = CW'(n); verify_en_i = verify;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (n == 0) check({tag, "_n0_done_next_cycle"}, 64'(done_o), 64'(1));
    fork
      begin
        bit stop;
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
          int gap; bit hs; int budget;
          gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
          hs = 1'b0; budget = 0;
          src_valid_i = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
          src_valid_i = 1'b1; src_data_i = words[i];
          while (!hs && !stop) begin
            @(negedge clk);
            if (!busy_o || budget >= 1000) stop = 1'b1;
            else begin hs = src_ready_o; @(posedge clk); #1; budget++; end
          end
        end
        src_valid_i = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(done_o || error_o) && cyc < 5000);
        check({tag, "_finish_in_budget"}, 64'(cyc < 5000), 64'(1));
        run_end = 1'b1;
      end
      begin
        while (!run_end) begin
          @(posedge clk); #1;
          start_i = 1'b0;
          if (spam && !run_end && busy_o && $urandom_range(3, 0) == 0) begin
            start_i = 1'b1; base_addr_i = AW'($urandom);
            num_words_i = CW'($urandom_range(9, 1)); verify_en_i = ~verify;
          end
        end
        start_i = 1'b0;
      end
    join
    fe_exp = fe_exp | exp_done;
    busy_cycles = busy_cnt;
    check({tag, "_done"}, 64'(done_o), 64'(exp_done));
    check({tag, "_error"}, 64'(error_o), 64'(exp_err));
    check({tag, "_err_addr"}, 64'(err_addr_o), 64'(exp_eaddr));
    check({tag, "_fetch_enable"}, 64'(fetch_enable_o), 64'(fe_exp));
    check({tag, "_busy_low"}, 64'(busy_o), 64'(0));
    check({tag, "_ready_low"}, 64'(src_ready_o), 64'(0));
    check({tag, "_num_writes"}, 64'(wr_log.size()), 64'(exp_q.size()));
    cmp_n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < cmp_n; i++) begin
      check($sformatf("%s_w%0d_addr", tag, i), 64'(wr_log[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_w%0d_data", tag, i), 64'(wr_log[i].data), 64'(exp_q[i].data));
    end
  endtask

  typedef struct {
    logic [AW-1:0] base; int n; bit verify; bit cen; logic [AW-1:0] caddr;
    bit exp_done; bit exp_err; logic [AW-1:0] exp_eaddr; int exp_writes; int exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] words[$];
    int busy_cycles;
    vecs[0] = '{base:22'h180, n:4, verify:1'b1, cen:1'b1, caddr:22'h188,
                exp_done:1'b0, exp_err:1'b1, exp_eaddr:22'h188, exp_writes:3,
                exp_busy:2*(3+WR+RD) + (1+WR+1+RD)};
    vecs[1] = '{base:22'h180, n:4, verify:1'b0, cen:1'b0, caddr:22'h0,
                exp_done:1'b1, exp_err:1'b0, exp_eaddr:22'h0, exp_writes:4, exp_busy:4*(2+WR)};
    vecs[2] = '{base:22'h180, n:4, verify:1'b1, cen:1'b0, caddr:22'h0,
                exp_done:1'b1, exp_err:1'b0, exp_eaddr:22'h0, exp_writes:4, exp_busy:4*(2+WR+1+RD)};
    vecs[3] = '{base:22'h183, n:2, verify:1'b0, cen:1'b0, caddr:22'h0,
                exp_done:1'b1, exp_err:1'b0, exp_eaddr:22'h0, exp_writes:2, exp_busy:2*(2+WR)};
    vecs[4] = '{base:22'h0, n:0, verify:1'b1, cen:1'b0, caddr:22'h0,
                exp_done:1'b1, exp_err:1'b0, exp_eaddr:22'h0, exp_writes:0, exp_busy:0};
    vecs[5] = '{base:22'h3FFFFC, n:2, verify:1'b1, cen:1'b0, caddr:22'h0,
                exp_done:1'b1, exp_err:1'b0, exp_eaddr:22'h0, exp_writes:2, exp_busy:2*(3+WR+RD)};

    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; num_words_i = '0; verify_en_i = 1'b0;
    src_valid_i = 1'b0; src_data_i = '0;
    for (int k = 0; k <= RD; k++) rd_pipe[k] = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_ctrl", 64'({src_ready_o, mem_en_o, mem_we_o, mem_be_o, lim_block_o, busy_o,
                           done_o, error_o, fetch_enable_o}), 64'(0));
    check("rst_addr", 64'(mem_addr_o), 64'(0));
    check("rst_wdata", 64'(mem_wdata_o), 64'(0));
    check("rst_err_addr", 64'(err_addr_o), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("idle_ready", 64'(src_ready_o), 64'(0));
    check("idle_busy", 64'(busy_o), 64'(0));
    check("idle_en", 64'(mem_en_o), 64'(0));

    // Directed loads from the table
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      words = {};
      for (int i = 0; i < vecs[v].n; i++) words.push_back(32'hA0 + DW'(i));
      run_load(vecs[v].base, vecs[v].n, vecs[v].verify, vecs[v].cen, vecs[v].caddr,
               words, 0, 1'b0, tag, busy_cycles);
      check({tag, "_tbl_busy_cycles"}, 64'(busy_cycles), 64'(vecs[v].exp_busy));
      check({tag, "_tbl_writes"}, 64'(wr_log.size()), 64'(vecs[v].exp_writes));
      check({tag, "_tbl_done"}, 64'(done_o), 64'(vecs[v].exp_done));
      check({tag, "_tbl_error"}, 64'(error_o), 64'(vecs[v].exp_err));
      check({tag, "_tbl_err_addr"}, 64'(err_addr_o), 64'(vecs[v].exp_eaddr));
    end

    // Random loads with source gaps and start pulses while busy
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] base, caddr;
      int n, cidx;
      bit verify, cen;
      longint a;
      base = AW'($urandom);
      n = $urandom_range(8, 1);
      verify = 1'($urandom_range(1, 0));
      cen = verify && ($urandom_range(2, 0) == 0);
      cidx = $urandom_range(n - 1, 0);
      a = ((longint'(base) / 4) * 4 + 4 * cidx) % (longint'(1) << AW);
      caddr = a[AW-1:0];
      words = {};
      for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
      run_load(base, n, verify, cen, caddr, words, 7, 1'b1, $sformatf("rnd%0d", r), busy_cycles);
    end

    // Reset in the middle of a write burst
    corrupt_en = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 22'h40; num_words_i = 16'd3; verify_en_i = 1'b0;
    src_valid_i = 1'b1; src_data_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    start_i = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!mem_we_o && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check("midrst_write_seen", 64'(mem_we_o), 64'(1));
    end
    #2 rst_n = 1'b0;
    #1;
    fe_exp = 1'b0;
    check("midrst_en_drop", 64'({mem_en_o, mem_we_o}), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_fetch", 64'(fetch_enable_o), 64'(fe_exp));
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("midrst_no_resume", 64'({mem_en_o, busy_o, src_ready_o, done_o}), 64'(0));
    src_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
